pwm_capture: RTL and testbench
==============================

# pwm_capture

PWM measurement block, the receive end of the PWM link driven by `pwm_generator`. It samples an 8-bit PWM level bus and measures each complete period: total period length, high-time length and high-level value. Each measurement is published with a one-cycle valid strobe, so software can close the loop on `PERIOD`/`PULSE`/`SIZE` through an APB wrapper.

## Interface
- `SYNC_STAGES`, default 0: input synchronizer depth, 0–3. Use 0 when the generator shares `clk`.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ENABLE` in 1: capture enable.
- `PWM_IN` in 8: PWM level bus. Nonzero is high; 0 is low.
- `PERIOD` out 32: last measured period, in cycles, rising edge to rising edge.
- `PULSE` out 32: last measured high time, in cycles.
- `SIZE` out 8: `PWM_IN` value sampled on the first high cycle of the measured period.
- `VALID` out 1: one-cycle strobe when `PERIOD`/`PULSE`/`SIZE` update.
- `STUCK` out 1: one-cycle strobe when a period counter saturates, meaning no edge was seen.

## Operation
- Input path: `PWM_IN` passes through `SYNC_STAGES` registers, giving `pwm_s`. `hi = |pwm_s`.
- Counters: `period_cnt`, `high_cnt` and `size_q` (8 bits). Counters are 32 bits and saturate at 0xFFFF_FFFF; they never wrap.
- FSM states:
  - IDLE: wait for `hi=0`, so a partial first period is discarded. On `hi=0` go to ARM.
  - ARM: wait for `hi=1`. On it: `period_cnt<=1`, `high_cnt<=1`, `size_q<=pwm_s`, go to HIGH. No `VALID`, because there is no prior edge.
  - HIGH:
    - `hi=1`: `period_cnt++`, `high_cnt++`.
    - `hi=0`: `period_cnt++`, go to LOW.
  - LOW:
    - `hi=0`: `period_cnt++`.
    - `hi=1` (rising edge): `PERIOD<=period_cnt`, `PULSE<=high_cnt`, `SIZE<=size_q`, `VALID<=1`. Then `period_cnt<=1`, `high_cnt<=1`, `size_q<=pwm_s`, stay measuring in HIGH.
- Saturation: if `period_cnt==0xFFFF_FFFF` in HIGH or LOW and no edge occurs this cycle, pulse `STUCK` and go to IDLE. Outputs keep their old values.
- Simultaneous events:
  - A rising edge in the same cycle as saturation: the edge wins (normal `VALID` update, no `STUCK`).
  - `ENABLE=0` in the same cycle as an edge: `ENABLE` wins, no `VALID`.
- `ENABLE=0`:
  - Next state is IDLE and counters clear.
  - `PERIOD`/`PULSE`/`SIZE` hold their last values.
  - `VALID` and `STUCK` are held at 0.
  - Re-enable restarts from IDLE, so the first `VALID` comes after two rising edges.
- A level change while high (e.g. `SIZE` retuned mid-pulse) does not count as an edge. `SIZE` reports the first high sample only.

## Timing
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE; counters and `size_q` are 0.
  - Synchronizer registers are 0.
  - Reset is effective immediately on assertion, including mid-period; no partial result is published.
- Latency: a rising edge on `pwm_s` sampled at posedge t makes `VALID`=1 and the new outputs visible in the cycle after t. `PWM_IN`-to-`pwm_s` adds `SYNC_STAGES` cycles.
- `VALID` and `STUCK` are registered, last exactly one cycle, and are never asserted together.
- Outputs are stable between `VALID` strobes.
- Minimum measurable waveform is high for 1 cycle, low for 1 cycle: `PERIOD`=2, `PULSE`=1.
- Always `PULSE < PERIOD`. A constant-high input is not a period; it ends in `STUCK`.

## Structure
- Shared package `pwm_pkg`:
  - `COUNT_W=32`, `SIZE_W=8`.
  - `COUNT_MAX`.
  - `typedef enum logic [1:0] {CAP_IDLE, CAP_ARM, CAP_HIGH, CAP_LOW} cap_state_t`.
- One natural sub-module, `sat_counter`: width-parameterized, with load-to-1, increment, clear and a `max` flag. It is instantiated twice, for `period_cnt` and `high_cnt`.
- The synchronizer is an inline generate loop, not a module.

## Test plan
- Reset/idle:
  - Stimulus: assert `rst` mid-HIGH, release, then drive `PWM_IN=0`.
  - Required: all outputs 0, no strobes, FSM in IDLE then ARM.
- Steady waveform (`SYNC_STAGES=0`):
  - Stimulus: `PWM_IN` = 0x80 for 3 cycles, 0 for 5 cycles, repeated.
  - Required: first `VALID` one cycle after the second rising edge with `PERIOD=8`, `PULSE=3`, `SIZE=0x80`; then `VALID` every 8 cycles.
- Back-to-back with the live generator:
  - Stimulus: drive `pwm_generator` into this block, then change its `PERIOD`/`PULSE`/`SIZE`.
  - Required: captured values track the new settings from the first complete new period.
- Start mid-high:
  - Stimulus: enable while `PWM_IN=0x10`.
  - Required: the partial period is discarded; no `VALID` until two full rising edges have been seen.
- Boundaries:
  - Stimulus: 1-high/1-low waveform.
  - Required: `PERIOD=2`, `PULSE=1` on every `VALID`.
  - Stimulus: `PWM_IN` held at 0x01 with `period_cnt` forced near `COUNT_MAX`.
  - Required: one `STUCK` pulse, FSM in IDLE, outputs held.
- Enable abort:
  - Stimulus: drop `ENABLE` on the cycle of a rising edge.
  - Required: no `VALID`, outputs retain the previous measurement, re-enable restarts from IDLE.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM link (generator and capture sides).
// Contents: counter and level widths, the counter saturation value, the
// capture FSM state type, and a helper that turns a level bus into a high bit.
package pwm_pkg;

  localparam int COUNT_W = 32;
  localparam int SIZE_W  = 8;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_ARM  = 2'd1,
    CAP_HIGH = 2'd2,
    CAP_LOW  = 2'd3
  } cap_state_t;

  // Any nonzero level on the bus counts as "high".
  function automatic logic level_is_high(input logic [SIZE_W-1:0] level);
    return |level;
  endfunction

endpackage

// File: rtl/pwm_capture_sat_counter.sv
// sat_counter: width-parameterized up-counter that sticks at all-ones.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   clr      : synchronous clear to 0 (highest priority)
//   load     : synchronous load of the value 1
//   inc      : increment by one unless already saturated
//   cnt      : current count
//   max      : high while cnt is all ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         max
);

  logic [W-1:0] cnt_r;

  // Count register: clear beats load beats increment; never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= {{(W-1){1'b0}}, 1'b1};
    end else if (inc && !max) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign max = (cnt_r == {W{1'b1}});

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures complete periods of an 8-bit PWM level bus.
// A period runs from one rising edge of the (optionally synchronized) bus to
// the next. Each completed period publishes PERIOD, PULSE (high time) and
// SIZE (level on the first high cycle) together with a one-cycle VALID.
// A period that never ends saturates the counter and raises STUCK instead.
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   ENABLE  : capture enable; low forces the FSM back to idle
//   PWM_IN  : PWM level bus, nonzero = high
//   PERIOD  : last measured period in cycles
//   PULSE   : last measured high time in cycles
//   SIZE    : level sampled on the first high cycle of that period
//   VALID   : one-cycle strobe when PERIOD/PULSE/SIZE update
//   STUCK   : one-cycle strobe when the period counter saturated
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ENABLE,
  input  logic [SIZE_W-1:0]  PWM_IN,
  output logic [COUNT_W-1:0] PERIOD,
  output logic [COUNT_W-1:0] PULSE,
  output logic [SIZE_W-1:0]  SIZE,
  output logic               VALID,
  output logic               STUCK
);

  // Synchronizer chain: tap 0 is the raw bus, the last tap is pwm_s.
  // With zero stages the chain degenerates to a wire.
  logic [SIZE_W-1:0] tap_s [SYNC_STAGES+1];

  assign tap_s[0] = PWM_IN;

  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
    logic [SIZE_W-1:0] stage_r;

    // One synchronizer stage.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_r <= {SIZE_W{1'b0}};
      end else begin
        stage_r <= tap_s[i];
      end
    end

    assign tap_s[i+1] = stage_r;
  end

  logic [SIZE_W-1:0] pwm_s;
  logic              hi_s;

  assign pwm_s = tap_s[SYNC_STAGES];
  assign hi_s  = level_is_high(pwm_s);

  cap_state_t         state_r;
  cap_state_t         state_nxt_s;
  logic [SIZE_W-1:0]  size_q_r;

  logic               cnt_clr_s;
  logic               cnt_load_s;
  logic               period_inc_s;
  logic               high_inc_s;
  logic               size_load_s;
  logic               valid_nxt_s;
  logic               stuck_nxt_s;

  logic [COUNT_W-1:0] period_cnt_s;
  logic [COUNT_W-1:0] high_cnt_s;
  logic               period_max_s;
  logic               high_max_s;

  sat_counter #(.W(COUNT_W)) u_period_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr_s),
    .load (cnt_load_s),
    .inc  (period_inc_s),
    .cnt  (period_cnt_s),
    .max  (period_max_s)
  );

  sat_counter #(.W(COUNT_W)) u_high_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr_s),
    .load (cnt_load_s),
    .inc  (high_inc_s),
    .cnt  (high_cnt_s),
    .max  (high_max_s)
  );

  // Next-state and counter control. A rising edge (LOW with hi) always
  // beats saturation; ENABLE low beats everything.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_clr_s    = 1'b0;
    cnt_load_s   = 1'b0;
    period_inc_s = 1'b0;
    high_inc_s   = 1'b0;
    size_load_s  = 1'b0;
    valid_nxt_s  = 1'b0;
    stuck_nxt_s  = 1'b0;

    if (!ENABLE) begin
      state_nxt_s = CAP_IDLE;
      cnt_clr_s   = 1'b1;
    end else begin
      case (state_r)
        CAP_IDLE: begin
          // Discard whatever partial period is in flight.
          if (!hi_s) begin
            state_nxt_s = CAP_ARM;
          end else begin
            state_nxt_s = CAP_IDLE;
          end
        end
        CAP_ARM: begin
          // First rising edge only starts a period; nothing to publish yet.
          if (hi_s) begin
            cnt_load_s  = 1'b1;
            size_load_s = 1'b1;
            state_nxt_s = CAP_HIGH;
          end else begin
            state_nxt_s = CAP_ARM;
          end
        end
        CAP_HIGH: begin
          if (period_max_s) begin
            stuck_nxt_s = 1'b1;
            cnt_clr_s   = 1'b1;
            state_nxt_s = CAP_IDLE;
          end else if (hi_s) begin
            period_inc_s = 1'b1;
            high_inc_s   = !high_max_s;
            state_nxt_s  = CAP_HIGH;
          end else begin
            period_inc_s = 1'b1;
            state_nxt_s  = CAP_LOW;
          end
        end
        CAP_LOW: begin
          if (hi_s) begin
            valid_nxt_s = 1'b1;
            cnt_load_s  = 1'b1;
            size_load_s = 1'b1;
            state_nxt_s = CAP_HIGH;
          end else if (period_max_s) begin
            stuck_nxt_s = 1'b1;
            cnt_clr_s   = 1'b1;
            state_nxt_s = CAP_IDLE;
          end else begin
            period_inc_s = 1'b1;
            state_nxt_s  = CAP_LOW;
          end
        end
        default: begin
          cnt_clr_s   = 1'b1;
          state_nxt_s = CAP_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= CAP_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Level captured on the first high cycle of the period being measured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q_r <= {SIZE_W{1'b0}};
    end else if (cnt_clr_s) begin
      size_q_r <= {SIZE_W{1'b0}};
    end else if (size_load_s) begin
      size_q_r <= pwm_s;
    end else begin
      size_q_r <= size_q_r;
    end
  end

  // Published results and strobes; results change only with VALID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PERIOD <= {COUNT_W{1'b0}};
      PULSE  <= {COUNT_W{1'b0}};
      SIZE   <= {SIZE_W{1'b0}};
      VALID  <= 1'b0;
      STUCK  <= 1'b0;
    end else begin
      VALID <= valid_nxt_s;
      STUCK <= stuck_nxt_s;
      if (valid_nxt_s) begin
        PERIOD <= period_cnt_s;
        PULSE  <= high_cnt_s;
        SIZE   <= size_q_r;
      end else begin
        PERIOD <= PERIOD;
        PULSE  <= PULSE;
        SIZE   <= SIZE;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized scoreboard bench for pwm_capture (SYNC_STAGES=0).
// A reference model watches the sampled bus and ENABLE each rising edge and
// queues the measurements the spec rules produce; a monitor on the falling
// edge pops one entry per DUT strobe and compares, and checks that the
// published outputs hold steady between strobes.
module tb_pwm_capture;
  import pwm_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               ENABLE;
  logic [7:0]         PWM_IN;
  logic [31:0]        PERIOD;
  logic [31:0]        PULSE;
  logic [7:0]         SIZE;
  logic               VALID;
  logic               STUCK;

  always #5 clk = ~clk;

  pwm_capture #(.SYNC_STAGES(0)) dut (
    .clk    (clk),
    .rst    (rst),
    .ENABLE (ENABLE),
    .PWM_IN (PWM_IN),
    .PERIOD (PERIOD),
    .PULSE  (PULSE),
    .SIZE   (SIZE),
    .VALID  (VALID),
    .STUCK  (STUCK)
  );

  typedef struct {
    bit          stuck;
    logic [31:0] period;
    logic [31:0] pulse;
    logic [7:0]  size;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  int  stuck_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference model: cycle indices and run lengths, not FSM states.
  bit      m_active;    // a period is being timed
  bit      m_have_low;  // a low sample was seen since (re)start
  bit      m_prev_hi;
  longint  m_pcnt;      // cycles since the start of the current period
  longint  m_hcnt;      // length of the high run that opened it
  logic [7:0] m_sz;

  always @(posedge clk) begin
    bit hi;
    hi = (PWM_IN != 8'h00);
    if (rst || !ENABLE) begin
      m_active   = 1'b0;
      m_have_low = 1'b0;
      m_prev_hi  = 1'b0;
    end else begin
      if (m_active) begin
        if (hi && !m_prev_hi) begin
          exp_q.push_back('{1'b0, m_pcnt[31:0], m_hcnt[31:0], m_sz});
          m_pcnt = 64'd1;
          m_hcnt = 64'd1;
          m_sz   = PWM_IN;
        end else if (m_pcnt == 64'hFFFF_FFFF) begin
          exp_q.push_back('{1'b1, 32'd0, 32'd0, 8'd0});
          m_active   = 1'b0;
          m_have_low = 1'b0;
        end else begin
          m_pcnt++;
          if (hi) m_hcnt++;
        end
      end else if (!hi) begin
        m_have_low = 1'b1;
      end else if (m_have_low) begin
        m_active = 1'b1;
        m_pcnt   = 64'd1;
        m_hcnt   = 64'd1;
        m_sz     = PWM_IN;
      end
      m_prev_hi = hi;
    end
  end

  // Monitor: compare every strobe against the queue; check holds otherwise.
  logic [31:0] last_period = 32'd0;
  logic [31:0] last_pulse  = 32'd0;
  logic [7:0]  last_size   = 8'd0;

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      exp_q.delete();
      last_period = 32'd0;
      last_pulse  = 32'd0;
      last_size   = 8'd0;
    end else if (VALID || STUCK) begin
      check("strobe_exclusive", {31'd0, VALID & STUCK}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, VALID, STUCK}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {31'd0, STUCK}, {31'd0, e.stuck});
        if (e.stuck) begin
          stuck_seen++;
          check("stuck_hold", {PERIOD ^ last_period} | {PULSE ^ last_pulse} | {24'd0, SIZE ^ last_size}, 32'd0);
        end else begin
          check("PERIOD", PERIOD, e.period);
          check("PULSE", PULSE, e.pulse);
          check("SIZE", {24'd0, SIZE}, {24'd0, e.size});
          check("pulse_lt_period", {31'd0, PULSE < PERIOD}, 32'd1);
          last_period = e.period;
          last_pulse  = e.pulse;
          last_size   = e.size;
        end
      end
    end else begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("missing_strobe", 32'd0, {31'd0, 1'b1});
      end
      check("hold", {PERIOD ^ last_period} | {PULSE ^ last_pulse} | {24'd0, SIZE ^ last_size}, 32'd0);
    end
  end

  task automatic wave(input logic [7:0] lvl, input int h, input int l, input bit retune);
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      PWM_IN = (retune && i > 0) ? (lvl ^ 8'h01) | 8'h02 : lvl;
    end
    for (int i = 0; i < l; i++) begin
      @(negedge clk);
      PWM_IN = 8'h00;
    end
  endtask

  initial begin
    logic [7:0] lvl;
    rst = 1'b1; ENABLE = 1'b0; PWM_IN = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_period", PERIOD, 32'd0);
    check("rst_pulse", PULSE, 32'd0);
    check("rst_size", {24'd0, SIZE}, 32'd0);
    check("rst_strobes", {30'd0, VALID, STUCK}, 32'd0);
    check("rst_state", {30'd0, dut.state_r}, {30'd0, CAP_IDLE});
    rst = 1'b0; ENABLE = 1'b1;

    // Steady 3-high / 5-low at 0x80.
    for (int p = 0; p < 6; p++) wave(8'h80, 3, 5, 1'b0);

    // Reset in the middle of a high phase.
    wave(8'h33, 2, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_period", PERIOD, 32'd0);
    check("midrst_pulse", PULSE, 32'd0);
    check("midrst_size", {24'd0, SIZE}, 32'd0);
    check("midrst_valid", {31'd0, VALID}, 32'd0);
    check("midrst_state", {30'd0, dut.state_r}, {30'd0, CAP_IDLE});
    PWM_IN = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arm_state", {30'd0, dut.state_r}, {30'd0, CAP_ARM});

    // Minimum waveform: 1 high / 1 low.
    for (int p = 0; p < 8; p++) wave(8'h01, 1, 1, 1'b0);

    // Random waveforms with occasional mid-pulse level changes.
    for (int p = 0; p < 40; p++) begin
      lvl = 8'($urandom_range(255, 1));
      wave(lvl, int'($urandom_range(6, 1)), int'($urandom_range(6, 1)), 1'($urandom_range(1, 0)));
    end

    // Enable while already high: the partial period must be discarded.
    @(negedge clk); ENABLE = 1'b0; PWM_IN = 8'h10;
    repeat (2) @(negedge clk);
    ENABLE = 1'b1;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 4; p++) wave(8'h10, 2, 3, 1'b0);

    // Drop ENABLE exactly on a rising edge, then re-enable.
    wave(8'h55, 2, 4, 1'b0);
    @(negedge clk); ENABLE = 1'b0; PWM_IN = 8'h55;
    @(negedge clk); PWM_IN = 8'h00;
    repeat (3) @(negedge clk);
    ENABLE = 1'b1;
    for (int p = 0; p < 4; p++) wave(8'h66, 3, 2, 1'b0);

    // Constant high with the period counter pushed near saturation.
    wave(8'h01, 3, 0, 1'b0);
    @(negedge clk);
    PWM_IN = 8'h01;
    force dut.u_period_cnt.cnt_r = 32'hFFFF_FFFC;
    m_pcnt = 64'hFFFF_FFFC;
    #1 release dut.u_period_cnt.cnt_r;
    repeat (6) @(negedge clk);
    check("stuck_count", stuck_seen, 32'd1);
    check("stuck_state", {30'd0, dut.state_r}, {30'd0, CAP_IDLE});

    // Recover after STUCK, then drain.
    for (int p = 0; p < 3; p++) wave(8'h22, 2, 2, 1'b0);
    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
